// File: rtl/boot_loader_p_if.sv
// Byte-stream, transmit handshake and program-RAM port bundle of the UART boot loader.
// The master side is the loader; the slave side is the UART pair plus program RAM.
interface boot_loader_p_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    input  rx_byte, rx_valid, tx_ready, ram_rdata,
    output tx_byte, tx_valid, ram_en, ram_we, ram_adr, ram_wdata
  );

  modport slave (
    output rx_byte, rx_valid, tx_ready, ram_rdata,
    input  tx_byte, tx_valid, ram_en, ram_we, ram_adr, ram_wdata
  );
endinterface

// File: rtl/boot_loader_p.sv
// UART boot loader: assembles words from received bytes into program RAM, verifies a trailing
// checksum before releasing the core, and dumps RAM back over the transmit handshake on request.
module boot_loader_p #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned TX_GAP     = 18000,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            scan_memory,
  boot_loader_p_if.master bus,
  output logic            boot,
  output logic            load_err,
  output logic            dump_done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam int unsigned TO_W  = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADR = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((TX_GAP > 0) ? TX_GAP - 1 : 0);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    LOAD_WAIT,
    LOAD_WRITE,
    CHECK_WAIT,
    RUN,
    DUMP_READ,
    DUMP_LATCH,
    DUMP_SEND,
    DUMP_GAP,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  byte_cnt, tx_idx;
  logic [TO_W-1:0]   idle_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] word, shreg;
  logic [7:0]        sum, word_sum, chk_total;

  logic accept, word_done, tx_last;

  // Only the two load states listen to the byte stream; CHECK_WAIT takes its byte separately.
  assign accept    = ce && bus.rx_valid && (state == LOAD_WAIT || state == LOAD_WRITE);
  assign word_done = accept && (byte_cnt == LAST_IDX);
  assign chk_total = sum + bus.rx_byte;
  assign tx_last   = bus.tx_ready && (tx_idx == LAST_IDX);

  always_comb begin
    word_sum = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      word_sum = word_sum + word[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_WAIT;
    end else if (ce) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_adr   = '0;
    bus.ram_wdata = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_byte   = '0;
    boot          = 1'b1;
    dump_done     = 1'b0;

    unique case (state)
      LOAD_WRITE: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_adr   = wr_ptr;
        bus.ram_wdata = word;
      end
      RUN:        boot = 1'b0;
      DUMP_READ: begin
        bus.ram_en  = 1'b1;
        bus.ram_adr = rd_ptr;
      end
      DUMP_SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = shreg[DATA_W-1 -: 8];
      end
      DONE: begin
        boot      = 1'b0;
        dump_done = 1'b1;
      end
      default: ;
    endcase

    unique case (state)
      LOAD_WAIT:  if (word_done) state_n = LOAD_WRITE;
      LOAD_WRITE: state_n = (wr_ptr == LAST_ADR) ? CHECK_WAIT : LOAD_WAIT;
      CHECK_WAIT: if (bus.rx_valid) state_n = (chk_total == 8'd0) ? RUN : LOAD_WAIT;
      RUN:        if (scan_memory) state_n = DUMP_READ;
      DUMP_READ:  state_n = DUMP_LATCH;
      DUMP_LATCH: state_n = DUMP_SEND;
      DUMP_SEND: begin
        if (tx_last) begin
          if (rd_ptr == LAST_ADR) state_n = DONE;
          else if (TX_GAP == 0)   state_n = DUMP_READ;
          else                    state_n = DUMP_GAP;
        end
      end
      DUMP_GAP:   if (gap_cnt == GAP_LAST) state_n = DUMP_READ;
      DONE:       state_n = DONE;
      default:    state_n = LOAD_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      word     <= '0;
      sum      <= '0;
      shreg    <= '0;
      tx_idx   <= '0;
      gap_cnt  <= '0;
      load_err <= 1'b0;
    end else if (ce) begin
      // A partial word older than RX_TIMEOUT idle cycles is dropped.
      if (accept) begin
        word     <= (word << 8) | DATA_W'(bus.rx_byte);
        idle_cnt <= '0;
        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      end else if (byte_cnt != '0) begin
        if (idle_cnt == TO_LAST) begin
          byte_cnt <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      unique case (state)
        LOAD_WRITE: begin
          sum <= sum + word_sum;
          if (wr_ptr != LAST_ADR) wr_ptr <= wr_ptr + 1'b1;
        end
        CHECK_WAIT: begin
          if (bus.rx_valid) begin
            if (chk_total == 8'd0) begin
              load_err <= 1'b0;
            end else begin
              load_err <= 1'b1;
              wr_ptr   <= '0;
              sum      <= '0;
              byte_cnt <= '0;
            end
          end
        end
        RUN: if (scan_memory) rd_ptr <= '0;
        DUMP_LATCH: begin
          shreg  <= bus.ram_rdata;
          tx_idx <= '0;
        end
        DUMP_SEND: begin
          if (bus.tx_ready) begin
            shreg  <= shreg << 8;
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == LAST_IDX) begin
              gap_cnt <= '0;
              if (TX_GAP == 0 && rd_ptr != LAST_ADR) rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DUMP_GAP: begin
          if (gap_cnt == GAP_LAST) rd_ptr <= rd_ptr + 1'b1;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_p.sv
// Bench for boot_loader_p: random images loaded and dumped, checked against an image-level
// model of what RAM and the transmit stream must contain.
module tb_boot_loader_p;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned TX_GAP     = 3;
  localparam int unsigned RX_TIMEOUT = 20;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned BYTES      = 2;

  logic clk = 1'b0;
  logic rst, ce, scan_memory;
  logic boot, load_err, dump_done;
  bit   ce_alt;

  boot_loader_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  boot_loader_p #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TX_GAP(TX_GAP), .RX_TIMEOUT(RX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .scan_memory(scan_memory), .bus(bus),
    .boot(boot), .load_err(load_err), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_adr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_adr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [ADDR_W-1:0] adr; logic [DATA_W-1:0] data; } wr_t;
  wr_t               wr_log[$], exp_wr[$];
  logic [7:0]        tx_log[$];
  int                gap_log[$];
  logic [DATA_W-1:0] img [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];

  // Observers sample mid-cycle: a write or transfer is logged when it will take effect next edge.
  logic       prev_valid, prev_acc;
  logic [7:0] prev_byte;
  bit         seen_tx;
  int         idle_run;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      seen_tx    = 1'b0;
      idle_run   = 0;
    end else begin
      if (prev_valid && !prev_acc) begin
        chk("tx_hold_valid", bus.tx_valid, 1);
        chk("tx_hold_byte", bus.tx_byte, prev_byte);
      end
      if (ce && bus.ram_we) wr_log.push_back('{bus.ram_adr, bus.ram_wdata});
      if (ce && bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_byte);
      if (ce) begin
        if (bus.tx_valid) begin
          if (seen_tx && idle_run > 0) gap_log.push_back(idle_run);
          idle_run = 0;
          seen_tx  = 1'b1;
        end else if (seen_tx) begin
          idle_run++;
        end
      end
      prev_valid = bus.tx_valid;
      prev_acc   = ce && bus.tx_ready;
      prev_byte  = bus.tx_byte;
    end
  end

  task automatic cyc(input logic v);
    bus.rx_valid = v;
    ce = ce_alt ? ~ce : 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (ce_alt && ce) cyc(1'b0);
    bus.rx_byte = b;
    cyc(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce = 1'b1;
    ce_alt = 1'b0;
    scan_memory = 1'b0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0);
    wr_log.delete();
    exp_wr.delete();
    tx_log.delete();
    gap_log.delete();
  endtask

  task automatic rand_img();
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'($urandom);
  endtask

  task automatic load_image(input bit bad, input string tag);
    logic [7:0] s, b, cs;
    s = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = int'(BYTES) - 1; j >= 0; j--) begin
        b = img[i][j*8 +: 8];
        s = s + b;
        send_byte(b);
        if (j == 0) begin
          chk({tag, "_we"}, bus.ram_we, 1);
          chk({tag, "_adr"}, bus.ram_adr, i);
          chk({tag, "_wdata"}, bus.ram_wdata, img[i]);
          exp_wr.push_back('{ADDR_W'(i), img[i]});
          if (ce_alt) begin
            cyc(1'b0);
            chk({tag, "_we_frozen"}, bus.ram_we, 1);
            cyc(1'b0);
            chk({tag, "_we_end"}, bus.ram_we, 0);
          end else begin
            cyc(1'b0);
            chk({tag, "_we_end"}, bus.ram_we, 0);
            cyc(1'b0);
          end
        end else begin
          idle(2);
        end
      end
    end
    cs = 8'd0 - s;
    if (bad) cs = cs + 8'($urandom_range(1, 255));
    send_byte(cs);
    chk({tag, "_boot"}, boot, bad);
    chk({tag, "_load_err"}, load_err, bad);
    if (!bad) model_mem = img;
    idle(2);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
      chk({tag, "_wr_adr"}, wr_log[i].adr, exp_wr[i].adr);
      chk({tag, "_wr_data"}, wr_log[i].data, exp_wr[i].data);
    end
    wr_log.delete();
    exp_wr.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] exp_bytes[$];
    int k;

    rst = 1'b1;
    ce = 1'b1;
    ce_alt = 1'b0;
    scan_memory = 1'b0;
    bus.rx_byte = 8'd0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_boot", boot, 1);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_adr", bus.ram_adr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_dump_done", dump_done, 0);
    rst = 1'b0;
    cyc(1'b0);

    // Bad checksum, with a dump request that must be ignored while loading.
    rand_img();
    scan_memory = 1'b1;
    load_image(1'b1, "bad");
    chk("bad_no_tx", bus.tx_valid, 0);
    chk("bad_tx_count", tx_log.size(), 0);
    scan_memory = 1'b0;
    check_writes("bad");

    // Stale partial byte times out; reload starts again at address 0 and clears load_err.
    send_byte(8'hAA);
    idle(25);
    rand_img();
    img[0] = 16'h1122;
    load_image(1'b0, "tmo");
    check_writes("tmo");

    // Dump with toggling back-pressure; request dropped mid-dump has no effect.
    tx_log.delete();
    gap_log.delete();
    scan_memory = 1'b1;
    bus.tx_ready = 1'b0;
    for (k = 0; k < 400 && !dump_done; k++) begin
      bus.tx_ready = ~bus.tx_ready;
      if (tx_log.size() >= 1) scan_memory = 1'b0;
      cyc(1'b0);
    end
    chk("dump_done", dump_done, 1);
    chk("dump_boot", boot, 0);
    exp_bytes.delete();
    for (int i = 0; i < DEPTH; i++)
      for (int j = int'(BYTES) - 1; j >= 0; j--) exp_bytes.push_back(model_mem[i][j*8 +: 8]);
    chk("dump_count", tx_log.size(), exp_bytes.size());
    for (int i = 0; i < tx_log.size() && i < exp_bytes.size(); i++)
      chk("dump_byte", tx_log[i], exp_bytes[i]);
    chk("dump_gap_count", gap_log.size(), DEPTH - 1);
    foreach (gap_log[i]) chk("dump_gap_len", gap_log[i], TX_GAP + 2);
    scan_memory = 1'b0;
    bus.tx_ready = 1'b0;
    idle(3);
    chk("done_sticky", dump_done, 1);

    // Load with ce alternating 1/0.
    do_reset();
    ce_alt = 1'b1;
    rand_img();
    load_image(1'b0, "ceg");
    check_writes("ceg");
    ce_alt = 1'b0;

    // Dump, freeze with ce=0 after the third byte, then reset mid-dump.
    tx_log.delete();
    scan_memory = 1'b1;
    bus.tx_ready = 1'b1;
    for (k = 0; k < 200 && tx_log.size() < 3; k++) cyc(1'b0);
    chk("mid_count", tx_log.size(), 3);
    for (int i = 0; i < tx_log.size() && i < 3; i++)
      chk("mid_byte", tx_log[i], model_mem[i/2][(1 - i % 2)*8 +: 8]);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("freeze_valid", bus.tx_valid, 1);
    chk("freeze_byte", bus.tx_byte, model_mem[1][7:0]);
    chk("freeze_count", tx_log.size(), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_boot", boot, 1);
    chk("mid_rst_ram_adr", bus.ram_adr, 0);
    chk("mid_rst_dump_done", dump_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce = 1'b1;
    scan_memory = 1'b0;
    bus.tx_ready = 1'b0;
    cyc(1'b0);
    wr_log.delete();
    exp_wr.delete();
    rand_img();
    load_image(1'b0, "post");
    check_writes("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
